// File: rtl/usb_dma_pkg.sv
// Shared types and helpers for the USB DMA AHB-lite to AXI4 bridge.
package usb_dma_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE    = 3'd0;
  localparam state_t WR_DATA = 3'd1;
  localparam state_t WR_REQ  = 3'd2;
  localparam state_t WR_RESP = 3'd3;
  localparam state_t RD_ADDR = 3'd4;
  localparam state_t RD_DATA = 3'd5;
  localparam state_t ERR1    = 3'd6;
  localparam state_t ERR2    = 3'd7;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  function automatic logic [3:0] ahb_wstrb(input logic [2:0] size, input logic [1:0] addr_lo);
    case (size)
      3'd0:    return 4'b0001 << addr_lo;
      3'd1:    return 4'b0011 << addr_lo;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic ahb_size_legal(input logic [2:0] size, input logic [1:0] addr_lo);
    case (size)
      3'd0:    return 1'b1;
      3'd1:    return !addr_lo[0];
      3'd2:    return addr_lo == 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic axi_resp_ok(input logic [1:0] resp);
    return (resp == RESP_OKAY) || (resp == RESP_EXOKAY);
  endfunction

endpackage

// File: rtl/axi_bus.sv
// Minimal AXI4 bus bundle with master/slave views.
interface AXI_BUS #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4
);
  logic [ID_WIDTH-1:0]     aw_id;
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic [7:0]              aw_len;
  logic [2:0]              aw_size;
  logic [1:0]              aw_burst;
  logic                    aw_lock;
  logic [3:0]              aw_cache;
  logic [2:0]              aw_prot;
  logic                    aw_valid;
  logic                    aw_ready;
  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    w_last;
  logic                    w_valid;
  logic                    w_ready;
  logic [ID_WIDTH-1:0]     b_id;
  logic [1:0]              b_resp;
  logic                    b_valid;
  logic                    b_ready;
  logic [ID_WIDTH-1:0]     ar_id;
  logic [ADDR_WIDTH-1:0]   ar_addr;
  logic [7:0]              ar_len;
  logic [2:0]              ar_size;
  logic [1:0]              ar_burst;
  logic                    ar_lock;
  logic [3:0]              ar_cache;
  logic [2:0]              ar_prot;
  logic                    ar_valid;
  logic                    ar_ready;
  logic [ID_WIDTH-1:0]     r_id;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [1:0]              r_resp;
  logic                    r_last;
  logic                    r_valid;
  logic                    r_ready;

  modport Master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_valid,
    output r_ready
  );

  modport Slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_valid,
    output w_ready,
    output b_id, b_resp, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_valid,
    input  r_ready
  );
endinterface

// File: rtl/usb_dma_ahb2axi.sv
// AHB-lite DMA slave to AXI4 master: each AHB beat becomes one single-beat,
// non-posted AXI transaction while the AHB side is held with hready low.
module usb_dma_ahb2axi
  import usb_dma_pkg::*;
#(
  parameter int unsigned AXI_ID     = 0,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  s_hsel,
  input  logic [ADDR_WIDTH-1:0] s_haddr,
  input  logic [1:0]            s_htrans,
  input  logic                  s_hwrite,
  input  logic [2:0]            s_hsize,
  input  logic [2:0]            s_hburst,
  input  logic [DATA_WIDTH-1:0] s_hwdata,
  output logic [DATA_WIDTH-1:0] s_hrdata,
  output logic                  s_hready,
  output logic                  s_hresp,
  AXI_BUS.Master                mst
);

  if (DATA_WIDTH != 32) begin : g_bad_width
    $error("usb_dma_ahb2axi supports DATA_WIDTH == 32 only");
  end

  localparam logic [ID_WIDTH-1:0] ID_C = ID_WIDTH'(AXI_ID);

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   haddr_q;
  logic                    hwrite_q;
  logic [2:0]              hsize_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [3:0]              wstrb_q;
  logic [DATA_WIDTH-1:0]   hrdata_q;
  logic                    aw_valid_q, w_valid_q, ar_valid_q;
  logic                    accept;
  logic                    aw_done, w_done;

  assign s_hready = (state == IDLE) || (state == ERR2);
  assign s_hresp  = (state == ERR1) || (state == ERR2);
  assign s_hrdata = hrdata_q;
  assign accept   = s_hsel & s_htrans[1] & s_hready;

  // A channel counts as done once its valid has dropped or is being accepted now.
  assign aw_done = !aw_valid_q || mst.aw_ready;
  assign w_done  = !w_valid_q  || mst.w_ready;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state      <= IDLE;
      haddr_q    <= '0;
      hwrite_q   <= 1'b0;
      hsize_q    <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      hrdata_q   <= '0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      ar_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE, ERR2: begin
          state <= IDLE;
          if (accept) begin
            haddr_q  <= s_haddr;
            hwrite_q <= s_hwrite;
            hsize_q  <= s_hsize;
            if (!ahb_size_legal(s_hsize, s_haddr[1:0])) begin
              state <= ERR1;
            end else if (s_hwrite) begin
              state <= WR_DATA;
            end else begin
              state      <= RD_ADDR;
              ar_valid_q <= 1'b1;
            end
          end
        end
        WR_DATA: begin
          wdata_q    <= s_hwdata;
          wstrb_q    <= ahb_wstrb(hsize_q, haddr_q[1:0]);
          aw_valid_q <= 1'b1;
          w_valid_q  <= 1'b1;
          state      <= WR_REQ;
        end
        WR_REQ: begin
          if (mst.aw_ready) aw_valid_q <= 1'b0;
          if (mst.w_ready)  w_valid_q  <= 1'b0;
          if (aw_done && w_done) state <= WR_RESP;
        end
        WR_RESP: begin
          if (mst.b_valid) state <= axi_resp_ok(mst.b_resp) ? IDLE : ERR1;
        end
        RD_ADDR: begin
          if (mst.ar_ready) begin
            ar_valid_q <= 1'b0;
            state      <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (mst.r_valid) begin
            if (axi_resp_ok(mst.r_resp)) begin
              hrdata_q <= mst.r_data;
              state    <= IDLE;
            end else begin
              state <= ERR1;
            end
          end
        end
        ERR1:    state <= ERR2;
        default: state <= IDLE;
      endcase
    end
  end

  assign mst.aw_id    = ID_C;
  assign mst.aw_addr  = haddr_q;
  assign mst.aw_len   = 8'd0;
  assign mst.aw_size  = hsize_q;
  assign mst.aw_burst = BURST_INCR;
  assign mst.aw_lock  = 1'b0;
  assign mst.aw_cache = 4'd0;
  assign mst.aw_prot  = 3'd0;
  assign mst.aw_valid = aw_valid_q;
  assign mst.w_data   = wdata_q;
  assign mst.w_strb   = wstrb_q;
  assign mst.w_last   = 1'b1;
  assign mst.w_valid  = w_valid_q;
  assign mst.b_ready  = (state == WR_RESP);
  assign mst.ar_id    = ID_C;
  assign mst.ar_addr  = haddr_q;
  assign mst.ar_len   = 8'd0;
  assign mst.ar_size  = hsize_q;
  assign mst.ar_burst = BURST_INCR;
  assign mst.ar_lock  = 1'b0;
  assign mst.ar_cache = 4'd0;
  assign mst.ar_prot  = 3'd0;
  assign mst.ar_valid = ar_valid_q;
  assign mst.r_ready  = (state == RD_DATA);

  logic unused;
  assign unused = ^{s_htrans[0], s_hburst, hwrite_q, mst.b_id, mst.r_id, mst.r_last};

endmodule

// File: tb/tb_usb_dma_ahb2axi.sv
// Directed bench: AHB master driver, delay-configurable AXI slave, scoreboard queues.
module tb_usb_dma_ahb2axi;

  logic        aclk = 1'b0;
  logic        areset;
  logic        s_hsel;
  logic [31:0] s_haddr;
  logic [1:0]  s_htrans;
  logic        s_hwrite;
  logic [2:0]  s_hsize;
  logic [2:0]  s_hburst;
  logic [31:0] s_hwdata;
  logic [31:0] s_hrdata;
  logic        s_hready;
  logic        s_hresp;

  AXI_BUS #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4)) mst ();

  usb_dma_ahb2axi #(.AXI_ID(0), .ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .aclk(aclk), .areset(areset),
    .s_hsel(s_hsel), .s_haddr(s_haddr), .s_htrans(s_htrans), .s_hwrite(s_hwrite),
    .s_hsize(s_hsize), .s_hburst(s_hburst), .s_hwdata(s_hwdata),
    .s_hrdata(s_hrdata), .s_hready(s_hready), .s_hresp(s_hresp),
    .mst(mst)
  );

  always #5 aclk = ~aclk;

  int vectors = 0;
  int miscompares = 0;

  logic [63:0] exp_aw[$];
  logic [63:0] exp_w[$];
  logic [63:0] exp_ar[$];
  logic [31:0] exp_rd[$];

  int          aw_dly = 0, w_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0]  b_resp_v = 2'b00, r_resp_v = 2'b00;
  logic [31:0] r_data_v = '0;
  bit          kill = 0;
  bit          mon_idle = 0;
  int          spurious = 0, bad_bready = 0;
  bit          w_early = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] a_exp(input logic [31:0] a, input logic [2:0] s);
    return {7'd0, a, s, 8'd0, 2'b01, 4'd0, 1'b0, 4'd0, 3'd0};
  endfunction

  // AXI slave: AW, W, B, AR/R each run independently with programmable delays.
  initial begin
    mst.aw_ready = 1'b0;
    forever begin
      @(negedge aclk);
      if (mst.aw_valid && !areset) begin
        repeat (aw_dly) @(negedge aclk);
        if (exp_aw.size() == 0) chk("aw_unexpected", 64'(exp_aw.size()), 64'd1);
        else chk("aw_fields", {7'd0, mst.aw_addr, mst.aw_size, mst.aw_len, mst.aw_burst, mst.aw_id,
                              mst.aw_lock, mst.aw_cache, mst.aw_prot}, exp_aw.pop_front());
        mst.aw_ready = 1'b1;
        @(negedge aclk);
        mst.aw_ready = 1'b0;
      end
    end
  end

  initial begin
    mst.w_ready = 1'b0;
    forever begin
      @(negedge aclk);
      if (mst.w_valid && !areset) begin
        repeat (w_dly) @(negedge aclk);
        if (exp_w.size() == 0) chk("w_unexpected", 64'(exp_w.size()), 64'd1);
        else chk("w_fields", {27'd0, mst.w_data, mst.w_strb, mst.w_last}, exp_w.pop_front());
        mst.w_ready = 1'b1;
        @(negedge aclk);
        mst.w_ready = 1'b0;
      end
    end
  end

  initial begin
    mst.b_valid = 1'b0; mst.b_resp = 2'b00; mst.b_id = '0;
    forever begin
      @(negedge aclk);
      if (mst.b_ready && !areset) begin
        mst.b_valid = 1'b1;
        mst.b_resp  = b_resp_v;
        @(negedge aclk);
        mst.b_valid = 1'b0;
      end
    end
  end

  initial begin
    mst.ar_ready = 1'b0; mst.r_valid = 1'b0; mst.r_data = '0;
    mst.r_resp = 2'b00; mst.r_id = '0; mst.r_last = 1'b1;
    forever begin
      @(negedge aclk);
      if (mst.ar_valid && !areset) begin
        repeat (ar_dly) @(negedge aclk);
        if (exp_ar.size() == 0) chk("ar_unexpected", 64'(exp_ar.size()), 64'd1);
        else chk("ar_fields", {7'd0, mst.ar_addr, mst.ar_size, mst.ar_len, mst.ar_burst, mst.ar_id,
                              mst.ar_lock, mst.ar_cache, mst.ar_prot}, exp_ar.pop_front());
        mst.ar_ready = 1'b1;
        @(negedge aclk);
        mst.ar_ready = 1'b0;
        repeat (r_dly) @(negedge aclk);
        if (!kill) begin
          mst.r_valid = 1'b1;
          mst.r_data  = r_data_v;
          mst.r_resp  = r_resp_v;
          @(negedge aclk);
          mst.r_valid = 1'b0;
        end
      end
    end
  end

  always @(negedge aclk) begin
    if (mst.b_ready && mst.aw_valid) bad_bready++;
    if (mst.aw_valid && !mst.w_valid) w_early = 1;
    if (mon_idle && (mst.aw_valid || mst.w_valid || mst.ar_valid)) spurious++;
  end

  // Drives one address phase starting at the current negedge, then waits for hready.
  task automatic ahb_xfer(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                          input logic [31:0] wdata, output int low, output logic err);
    s_hsel = 1'b1; s_htrans = 2'b10; s_haddr = addr; s_hwrite = wr; s_hsize = size;
    @(negedge aclk);
    s_hsel = 1'b0; s_htrans = 2'b00; s_hwdata = wdata;
    low = 0; err = 1'b0;
    while (!s_hready && low < 200) begin
      low++;
      err = s_hresp;
      @(negedge aclk);
    end
    if (low >= 200) chk("hready_timeout", 64'(low), 64'd0);
  endtask

  int   low;
  logic err;
  int   n;

  initial begin
    areset = 1'b1; s_hsel = 1'b0; s_haddr = '0; s_htrans = 2'b00; s_hwrite = 1'b0;
    s_hsize = 3'd0; s_hburst = 3'd0; s_hwdata = '0;
    repeat (2) @(negedge aclk);
    chk("rst_hready", s_hready, 1'b1);
    chk("rst_hresp", s_hresp, 1'b0);
    chk("rst_hrdata", s_hrdata, 32'h0);
    chk("rst_valids", {mst.aw_valid, mst.w_valid, mst.ar_valid}, 3'b000);
    chk("rst_readys", {mst.b_ready, mst.r_ready}, 2'b00);
    areset = 1'b0;
    @(negedge aclk);

    // word write, zero-wait slave
    exp_aw.push_back(a_exp(32'h8000_0010, 3'd2));
    exp_w.push_back({27'd0, 32'hDEAD_BEEF, 4'hF, 1'b1});
    ahb_xfer(32'h8000_0010, 1'b1, 3'd2, 32'hDEAD_BEEF, low, err);
    chk("wr_word_low", 64'(low), 64'd3);
    chk("wr_word_err", {err, s_hresp}, 2'b00);

    // byte write at lane 3
    exp_aw.push_back(a_exp(32'h8000_0013, 3'd0));
    exp_w.push_back({27'd0, 32'hAB00_0000, 4'h8, 1'b1});
    ahb_xfer(32'h8000_0013, 1'b1, 3'd0, 32'hAB00_0000, low, err);
    chk("wr_byte_low", 64'(low), 64'd3);
    chk("wr_byte_err", {err, s_hresp}, 2'b00);

    // read with delayed AR and R
    ar_dly = 3; r_dly = 5; r_data_v = 32'h1234_5678;
    exp_ar.push_back(a_exp(32'h1000_0004, 3'd2));
    exp_rd.push_back(32'h1234_5678);
    ahb_xfer(32'h1000_0004, 1'b0, 3'd2, 32'h0, low, err);
    chk("rd_slow_low", 64'(low), 64'd10);
    chk("rd_slow_data", s_hrdata, exp_rd.pop_front());
    chk("rd_slow_err", {err, s_hresp}, 2'b00);
    ar_dly = 0; r_dly = 0;

    // W accepted four cycles before AW
    aw_dly = 4; w_early = 0; bad_bready = 0;
    exp_aw.push_back(a_exp(32'h8000_0020, 3'd2));
    exp_w.push_back({27'd0, 32'h0BAD_F00D, 4'hF, 1'b1});
    ahb_xfer(32'h8000_0020, 1'b1, 3'd2, 32'h0BAD_F00D, low, err);
    chk("wr_wfirst_low", 64'(low), 64'd7);
    chk("wr_wfirst_wdrop", {31'd0, w_early}, 32'd1);
    chk("wr_bready_early", 64'(bad_bready), 64'd0);
    aw_dly = 0;

    // DECERR read, then a NONSEQ presented in ERR2
    r_resp_v = 2'b11; r_data_v = 32'h5555_5555;
    exp_ar.push_back(a_exp(32'h1000_0008, 3'd2));
    ahb_xfer(32'h1000_0008, 1'b0, 3'd2, 32'h0, low, err);
    chk("rd_decerr_low", 64'(low), 64'd3);
    chk("rd_decerr_err1", {31'd0, err}, 32'd1);
    chk("rd_decerr_err2", {s_hready, s_hresp}, 2'b11);
    chk("rd_decerr_keep", s_hrdata, 32'h1234_5678);
    r_resp_v = 2'b00; r_data_v = 32'hCAFE_F00D;
    exp_ar.push_back(a_exp(32'h2000_0008, 3'd2));
    exp_rd.push_back(32'hCAFE_F00D);
    ahb_xfer(32'h2000_0008, 1'b0, 3'd2, 32'h0, low, err);
    chk("rd_in_err2_low", 64'(low), 64'd2);
    chk("rd_in_err2_data", s_hrdata, exp_rd.pop_front());
    chk("rd_in_err2_err", {err, s_hresp}, 2'b00);

    // SLVERR on a half-word write
    b_resp_v = 2'b10;
    exp_aw.push_back(a_exp(32'h8000_0002, 3'd1));
    exp_w.push_back({27'd0, 32'h1234_0000, 4'hC, 1'b1});
    ahb_xfer(32'h8000_0002, 1'b1, 3'd1, 32'h1234_0000, low, err);
    chk("wr_slverr_low", 64'(low), 64'd4);
    chk("wr_slverr_resp", {err, s_hready, s_hresp}, 3'b111);
    b_resp_v = 2'b00;
    @(negedge aclk);

    // illegal sizes: no AXI traffic, two-cycle error
    mon_idle = 1; spurious = 0;
    ahb_xfer(32'h8000_0001, 1'b1, 3'd1, 32'h0, low, err);
    chk("misalign_low", 64'(low), 64'd1);
    chk("misalign_resp", {err, s_hready, s_hresp}, 3'b111);
    ahb_xfer(32'h8000_0000, 1'b0, 3'd3, 32'h0, low, err);
    chk("size3_low", 64'(low), 64'd1);
    chk("size3_resp", {err, s_hready, s_hresp}, 3'b111);
    @(negedge aclk);
    mon_idle = 0;
    chk("illegal_no_axi", 64'(spurious), 64'd0);
    chk("queues_drained", 64'(exp_aw.size() + exp_w.size() + exp_ar.size()), 64'd0);

    // reset mid-RD_DATA
    r_dly = 30;
    exp_ar.push_back(a_exp(32'h3000_0000, 3'd2));
    s_hsel = 1'b1; s_htrans = 2'b10; s_haddr = 32'h3000_0000; s_hwrite = 1'b0; s_hsize = 3'd2;
    @(negedge aclk);
    s_hsel = 1'b0; s_htrans = 2'b00;
    n = 0;
    while (!mst.r_ready && n < 20) begin
      n++;
      @(negedge aclk);
    end
    chk("reached_rd_data", {31'd0, mst.r_ready}, 32'd1);
    kill = 1;
    areset = 1'b1;
    #1;
    chk("arst_hready", s_hready, 1'b1);
    chk("arst_hresp", s_hresp, 1'b0);
    chk("arst_hrdata", s_hrdata, 32'h0);
    chk("arst_axi", {mst.aw_valid, mst.w_valid, mst.ar_valid, mst.b_ready, mst.r_ready}, 5'b0);
    @(negedge aclk);
    areset = 1'b0;
    repeat (2) @(negedge aclk);
    chk("post_rst_idle", {s_hready, s_hresp}, 2'b10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/usb_dma_ahb2axi.md
Name: usb_dma_ahb2axi

Overview:
- Bridge from the USB OTG controller's AHB-lite DMA master port to a single AXI4 master port toward system memory.
- This is the reverse direction of the register-access path, which is AXI slave to AHB master.
- Every AHB beat (NONSEQ or SEQ) becomes one non-posted single-beat AXI transaction.
- The AHB master is stalled with hready low until the AXI response returns.

Parameters:
- AXI_ID, 0, constant ID driven on aw_id and ar_id.
- ADDR_WIDTH, 32, AHB and AXI address width.
- DATA_WIDTH, 32, data width. Only 32 is supported; elaboration fails otherwise.

Ports:
- aclk  in  1  single clock for both AHB and AXI sides.
- areset  in  1  asynchronous, active-high reset.
- s_hsel  in  1  AHB slave select.
- s_haddr  in  ADDR_WIDTH  AHB address.
- s_htrans  in  2  AHB transfer type. IDLE and BUSY are treated as no-transfer.
- s_hwrite  in  1  AHB transfer direction.
- s_hsize  in  3  AHB transfer size.
- s_hburst  in  3  ignored; each beat is handled independently.
- s_hwdata  in  DATA_WIDTH  AHB write data, valid in the data phase.
- s_hrdata  out  DATA_WIDTH  read data, registered.
- s_hready  out  1  transfer done (single-master; also used as hready_in).
- s_hresp  out  1  0 = OKAY, 1 = ERROR.
- mst  AXI_BUS.Master  -  AXI4 master port.
  - Fixed fields: len = 0, burst = INCR, cache/prot/lock = 0.
  - b_ready is high only in WR_RESP; r_ready is high only in RD_DATA.

Behaviour:
- Reset values: s_hready = 1, s_hresp = 0, s_hrdata = 0, all AXI valids = 0, state = IDLE. Reset mid-transaction abandons the transaction immediately.
- Accept condition: a transfer is accepted when s_hsel & s_htrans[1] & s_hready. The bridge then registers haddr, hwrite, hsize.
- Size check: a transfer is illegal if hsize > 2, or if it is misaligned (size 1 with addr[0] set; size 2 with addr[1:0] != 0). An illegal transfer goes to ERR1 with no AXI traffic.
- State IDLE: s_hready = 1.
  - Legal read goes to RD_ADDR.
  - Legal write goes to WR_DATA.
- State WR_DATA (AHB data-phase cycle): latch s_hwdata. Compute wstrb from hsize and addr[1:0] (byte 0001<<a, half 0011<<a, word 1111). Go to WR_REQ. s_hready = 0.
- State WR_REQ: aw_valid and w_valid are asserted together (w_last = 1) and deasserted independently on their own handshakes. Either order, or simultaneous acceptance, is legal. Go to WR_RESP once both have handshaken.
- State WR_RESP: b_ready = 1.
  - On b_valid with OKAY or EXOKAY, the next cycle is s_hready = 1, s_hresp = 0, state IDLE. A new address phase may be accepted in that same cycle.
  - On SLVERR or DECERR, go to ERR1.
- State RD_ADDR: ar_valid = 1 until ar_ready. Then RD_DATA.
- State RD_DATA: r_ready = 1.
  - On r_valid, register r_data into s_hrdata.
  - On OKAY, the next cycle is s_hready = 1 and state IDLE.
  - On error, go to ERR1 with s_hrdata unchanged.
  - r_last is ignored.
- ERR1: s_hresp = 1, s_hready = 0. Next state ERR2.
- ERR2: s_hresp = 1, s_hready = 1. An address phase presented here is accepted as normal (AHB two-cycle error response).
- Latency with zero-wait AXI:
  - Write: address phase T0, data T1, AW/W valid T2, B at T3, s_hready high T4.
  - Read: AR valid T1, R at T2, s_hready and data T3.
- No outstanding AXI transactions exist beyond one. The AXI valid signals are never deasserted before their handshake.
- hsize is passed through to aw_size / ar_size. The address is passed through unmodified.

Decomposition:
- Package usb_dma_pkg:
  - state enum (IDLE, WR_DATA, WR_REQ, WR_RESP, RD_ADDR, RD_DATA, ERR1, ERR2);
  - AXI resp constants;
  - function ahb_wstrb(size, addr_lo);
  - function ahb_size_legal(size, addr_lo).
- No sub-module: a single FSM plus the request and data registers.

Test Plan:
- Word write 0x8000_0010 = 0xDEADBEEF, zero-wait slave -> AW addr 0x8000_0010, size 2, len 0; W strb 0xF, last = 1; s_hready low for 3 cycles, then OKAY.
- Byte write at 0x8000_0013, hwdata 0xAB00_0000 -> wstrb 0x8, W data 0xAB00_0000, aw_size 0.
- Read at 0x1000_0004, slave returns 0x12345678 after ar_ready is delayed 3 cycles and r_valid is delayed 5 -> s_hrdata = 0x12345678 when s_hready rises; no earlier hready.
- Write with w_ready before aw_ready by 4 cycles -> w_valid low after its handshake; b_ready only after AW is accepted.
- Slave returns DECERR on a read -> s_hresp = 1 for 2 cycles with s_hready 0 then 1; a NONSEQ in ERR2 is accepted.
- Misaligned half-word at 0x...01, and hsize = 3 -> ERROR response with no AXI valids; areset pulsed mid-RD_DATA -> all outputs return to reset values asynchronously.
